// File: rtl/bp_accel_pkg.sv
// Shared definitions for the accelerator job scheduler: CSR map, job descriptor, FSM states.
package bp_accel_pkg;

  localparam logic [11:0] csr_off_a       = 12'h000;
  localparam logic [11:0] csr_off_b       = 12'h040;
  localparam logic [11:0] csr_off_len     = 12'h080;
  localparam logic [11:0] csr_off_start   = 12'h0C0;
  localparam logic [11:0] csr_off_status  = 12'h100;
  localparam logic [11:0] csr_off_res_ptr = 12'h140;

  // Pointers are held already zero-extended to the 64-bit CSR data width.
  typedef struct packed {
    logic [63:0] a_ptr;
    logic [63:0] b_ptr;
    logic [63:0] res_ptr;
    logic [3:0]  len;
  } job_desc_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_CHECK,
    S_WR_A,
    S_WR_B,
    S_WR_LEN,
    S_WR_RES,
    S_WR_START,
    S_POLL,
    S_COMPLETE
  } sched_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_accel_rr_arb.sv
// Round-robin arbiter: combinational grant searching from a registered pointer that
// moves one past the winner whenever the grant is taken.
module bp_accel_rr_arb
  import bp_accel_pkg::*;
#(
  parameter int num_req_p = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_i,
  input  logic                               advance_i,
  output logic [num_req_p-1:0]               grant_o,
  output logic [id_width(num_req_p)-1:0]     grant_id_o,
  output logic                               grant_v_o
);

  localparam int id_w = id_width(num_req_p);

  logic [id_w-1:0] ptr_q;
  logic [id_w-1:0] idx;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    grant_v_o  = 1'b0;
    idx        = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_w'((int'(ptr_q) + i) % num_req_p);
      if (!grant_v_o && req_i[idx]) begin
        grant_v_o    = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else if (advance_i && grant_v_o) begin
      ptr_q <= id_w'((int'(grant_id_o) + 1) % num_req_p);
    end
  end

endmodule

// File: rtl/bp_accel_job_scheduler.sv
// Shares one dot-product accelerator among requesters: arbitrate, program CSRs,
// start, poll STATUS, and hand a completion back to the owning requester.
module bp_accel_job_scheduler
  import bp_accel_pkg::*;
#(
  parameter int                      num_req_p    = 2,
  parameter int                      addr_width_p = 40,
  parameter logic [addr_width_p-1:0] csr_base_p   = '0,
  parameter int                      poll_limit_p = 1024,
  parameter int                      max_len_p    = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p-1:0]                job_v_i,
  output logic [num_req_p-1:0]                job_ready_o,
  input  logic [num_req_p*addr_width_p-1:0]   job_a_ptr_i,
  input  logic [num_req_p*addr_width_p-1:0]   job_b_ptr_i,
  input  logic [num_req_p*addr_width_p-1:0]   job_res_ptr_i,
  input  logic [num_req_p*4-1:0]              job_len_i,
  output logic                                cmd_v_o,
  output logic                                cmd_wr_o,
  output logic [addr_width_p-1:0]             cmd_addr_o,
  output logic [63:0]                         cmd_data_o,
  input  logic                                cmd_yumi_i,
  input  logic                                resp_v_i,
  input  logic [63:0]                         resp_data_i,
  output logic                                done_v_o,
  output logic [id_width(num_req_p)-1:0]      done_id_o,
  output logic                                done_err_o,
  input  logic                                done_yumi_i
);

  localparam int id_w  = id_width(num_req_p);
  localparam int cnt_w = $clog2(poll_limit_p + 1);

  sched_state_e   state_q, state_d;
  logic           wait_q, wait_d;       // 1 = command accepted, awaiting its response
  logic [cnt_w-1:0] cnt_q, cnt_d, cnt_inc;
  logic           err_q, err_d;
  logic [id_w-1:0] id_q;
  job_desc_t      job_q, sel_job;

  logic [num_req_p-1:0] gnt;
  logic [id_w-1:0]      gnt_id;
  logic                 gnt_v;
  logic                 latch_job;
  logic                 len_bad;
  logic [11:0]          cmd_off;
  logic                 resp_unused;

  bp_accel_rr_arb #(.num_req_p(num_req_p)) u_arb (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .req_i      (job_v_i),
    .advance_i  (latch_job),
    .grant_o    (gnt),
    .grant_id_o (gnt_id),
    .grant_v_o  (gnt_v)
  );

  always_comb begin
    sel_job.a_ptr   = 64'(job_a_ptr_i[gnt_id*addr_width_p +: addr_width_p]);
    sel_job.b_ptr   = 64'(job_b_ptr_i[gnt_id*addr_width_p +: addr_width_p]);
    sel_job.res_ptr = 64'(job_res_ptr_i[gnt_id*addr_width_p +: addr_width_p]);
    sel_job.len     = job_len_i[gnt_id*4 +: 4];
  end

  assign len_bad     = (job_q.len == 4'd0) || (int'(job_q.len) > max_len_p);
  assign cnt_inc     = cnt_q + cnt_w'(1);
  // Only STATUS bit0 carries meaning; the rest of the read data is don't-care.
  assign resp_unused = ^resp_data_i[63:1];

  // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    latch_job   = 1'b0;
    job_ready_o = '0;
    cmd_v_o     = 1'b0;
    cmd_wr_o    = 1'b0;
    cmd_addr_o  = '0;
    cmd_data_o  = '0;
    cmd_off     = '0;
    done_v_o    = 1'b0;
    done_id_o   = '0;
    done_err_o  = 1'b0;

    unique case (state_q)
      S_IDLE: if (|job_v_i) state_d = S_GRANT;

      S_GRANT: begin
        if (gnt_v) begin
          job_ready_o = gnt;
          latch_job   = 1'b1;
          state_d     = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        err_d   = len_bad;
        state_d = len_bad ? S_COMPLETE : S_WR_A;
      end

      S_WR_A, S_WR_B, S_WR_LEN, S_WR_RES, S_WR_START, S_POLL: begin
        if (!wait_q) begin
          cmd_v_o  = 1'b1;
          cmd_wr_o = (state_q != S_POLL);
          case (state_q)
            S_WR_A:     begin cmd_off = csr_off_a;       cmd_data_o = job_q.a_ptr;    end
            S_WR_B:     begin cmd_off = csr_off_b;       cmd_data_o = job_q.b_ptr;    end
            S_WR_LEN:   begin cmd_off = csr_off_len;     cmd_data_o = 64'(job_q.len); end
            S_WR_RES:   begin cmd_off = csr_off_res_ptr; cmd_data_o = job_q.res_ptr;  end
            S_WR_START: begin cmd_off = csr_off_start;   cmd_data_o = 64'd1;          end
            default:          cmd_off = csr_off_status;
          endcase
          cmd_addr_o = csr_base_p + addr_width_p'(cmd_off);
          if (cmd_yumi_i) wait_d = 1'b1;
        end else if (resp_v_i) begin
          wait_d = 1'b0;
          case (state_q)
            S_WR_A:     state_d = S_WR_B;
            S_WR_B:     state_d = S_WR_LEN;
            S_WR_LEN:   state_d = S_WR_RES;
            S_WR_RES:   state_d = S_WR_START;
            S_WR_START: state_d = S_POLL;
            default: begin
              if (resp_data_i[0]) begin
                err_d   = 1'b0;
                state_d = S_COMPLETE;
              end else if (int'(cnt_inc) == poll_limit_p) begin
                cnt_d   = cnt_inc;
                err_d   = 1'b1;
                state_d = S_COMPLETE;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          endcase
        end
      end

      S_COMPLETE: begin
        done_v_o   = 1'b1;
        done_id_o  = id_q;
        done_err_o = err_q;
        if (done_yumi_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (latch_job) id_q <= gnt_id;
    end
  end

  // NOTE: the descriptor payload is not reset; it is only read after a grant reloads it.
  always_ff @(posedge clk_i) begin
    if (latch_job) job_q <= sel_job;
  end

endmodule

// File: tb/tb_bp_accel_job_scheduler.sv
// Directed bench for bp_accel_job_scheduler: vector table of single jobs plus
// hand-written stall, reset-during-poll and round-robin sequences.
module tb_bp_accel_job_scheduler;

  localparam int NREQ = 2;
  localparam int AW   = 40;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [NREQ-1:0] job_v_i;
  logic [NREQ-1:0] job_ready_o;
  logic [NREQ*AW-1:0] job_a_ptr_i, job_b_ptr_i, job_res_ptr_i;
  logic [NREQ*4-1:0]  job_len_i;
  logic            cmd_v_o, cmd_wr_o;
  logic [AW-1:0]   cmd_addr_o;
  logic [63:0]     cmd_data_o;
  logic            cmd_yumi_i, resp_v_i;
  logic [63:0]     resp_data_i;
  logic            done_v_o;
  logic [0:0]      done_id_o;
  logic            done_err_o;
  logic            done_yumi_i;

  bp_accel_job_scheduler #(
    .num_req_p   (NREQ),
    .addr_width_p(AW),
    .csr_base_p  (40'h0),
    .poll_limit_p(4),
    .max_len_p   (8)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .job_v_i      (job_v_i),
    .job_ready_o  (job_ready_o),
    .job_a_ptr_i  (job_a_ptr_i),
    .job_b_ptr_i  (job_b_ptr_i),
    .job_res_ptr_i(job_res_ptr_i),
    .job_len_i    (job_len_i),
    .cmd_v_o      (cmd_v_o),
    .cmd_wr_o     (cmd_wr_o),
    .cmd_addr_o   (cmd_addr_o),
    .cmd_data_o   (cmd_data_o),
    .cmd_yumi_i   (cmd_yumi_i),
    .resp_v_i     (resp_v_i),
    .resp_data_i  (resp_data_i),
    .done_v_o     (done_v_o),
    .done_id_o    (done_id_o),
    .done_err_o   (done_err_o),
    .done_yumi_i  (done_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } cmd_t;

  typedef struct {
    int          req;
    logic [39:0] a;
    logic [39:0] b;
    logic [39:0] res;
    logic [3:0]  len;
    int          done_on;    // STATUS read number that returns done; 0 = never
    logic        exp_err;
    int          exp_reads;
    bit          exp_fast;   // rejected length: no CSR traffic at all
  } vec_t;

  int tests = 0;
  int fails = 0;

  cmd_t cmd_log[$];
  cmd_t exp_q[$];
  int   grant_log[$];
  int   done_id_q[$];
  int   done_err_q[$];
  int   cyc = 0, grant_cyc = 0, done_cyc = 0;
  int   reads = 0, done_on = 0, bad_grants = 0;
  bit   resp_pend = 0, keep_valid = 0, hold_on = 0;
  logic [63:0]     resp_val = '0;
  logic [AW-1:0]   hold_addr = 40'h040;
  logic [NREQ-1:0] drop_mask = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_job_ready"}, job_ready_o, 0);
    check({tag, "_cmd_v"},     cmd_v_o,     0);
    check({tag, "_cmd_wr"},    cmd_wr_o,    0);
    check({tag, "_cmd_addr"},  cmd_addr_o,  0);
    check({tag, "_cmd_data"},  cmd_data_o,  0);
    check({tag, "_done_v"},    done_v_o,    0);
    check({tag, "_done_id"},   done_id_o,   0);
    check({tag, "_done_err"},  done_err_o,  0);
  endtask

  task automatic set_desc(input int r, input logic [39:0] a, input logic [39:0] b,
                          input logic [39:0] res, input logic [3:0] len);
    job_a_ptr_i[r*AW +: AW]   = a;
    job_b_ptr_i[r*AW +: AW]   = b;
    job_res_ptr_i[r*AW +: AW] = res;
    job_len_i[r*4 +: 4]       = len;
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    grant_log.delete();
    done_id_q.delete();
    done_err_q.delete();
    bad_grants = 0;
  endtask

  // One cycle of requester / accelerator / completion-consumer behaviour, at the falling edge.
  task automatic step();
    @(negedge clk_i);
    cyc++;
    if (drop_mask != '0) begin
      job_v_i   = job_v_i & ~drop_mask;
      drop_mask = '0;
    end
    if ((job_ready_o & job_v_i) != '0) begin
      if (grant_log.size() != done_id_q.size()) bad_grants++;
      if ($countones(job_ready_o) != 1) bad_grants++;
      for (int r = 0; r < NREQ; r++) if (job_ready_o[r]) grant_log.push_back(r);
      grant_cyc = cyc;
      reads     = 0;
      if (!keep_valid) drop_mask = job_ready_o;
    end
    cmd_yumi_i  = 1'b0;
    resp_v_i    = 1'b0;
    resp_data_i = '0;
    done_yumi_i = 1'b0;
    if (resp_pend) begin
      resp_v_i    = 1'b1;
      resp_data_i = resp_val;
      resp_pend   = 0;
    end else if (cmd_v_o) begin
      if (hold_on && cmd_addr_o == hold_addr) begin
        resp_v_i    = 1'b1;          // stray response while command is still pending
        resp_data_i = 64'h1;
      end else begin
        cmd_yumi_i = 1'b1;
        cmd_log.push_back('{cmd_wr_o, cmd_addr_o, cmd_data_o});
        resp_pend = 1;
        if (!cmd_wr_o) begin
          reads++;
          resp_val = (done_on != 0 && reads >= done_on) ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFE;
        end else begin
          resp_val = 64'hDEAD_BEEF;
        end
      end
    end
    if (done_v_o) begin
      done_yumi_i = 1'b1;
      done_id_q.push_back(int'(done_id_o));
      done_err_q.push_back(int'(done_err_o));
      done_cyc = cyc;
    end
  endtask

  task automatic run_until_done(input int n, input int budget, input string tag);
    int c = 0;
    while (done_id_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check({tag, "_done_seen"}, done_id_q.size() >= n, 1);
  endtask

  vec_t vecs[6];
  int   alt_exp[4] = '{0, 1, 0, 1};

  initial begin
    vecs[0] = '{0, 40'h1000, 40'h2000, 40'h3000, 4'd4, 1, 1'b0, 1, 0};
    vecs[1] = '{1, 40'hAB_CDEF_0123, 40'h55_0000_0040, 40'h12_3456_789A, 4'd8, 3, 1'b0, 3, 0};
    vecs[2] = '{0, 40'h10, 40'h20, 40'h30, 4'd0, 1, 1'b1, 0, 1};
    vecs[3] = '{1, 40'h10, 40'h20, 40'h30, 4'd9, 1, 1'b1, 0, 1};
    vecs[4] = '{0, 40'h4000, 40'h5000, 40'h6000, 4'd1, 0, 1'b1, 4, 0};
    vecs[5] = '{1, 40'h10, 40'h20, 40'h30, 4'd15, 1, 1'b1, 0, 1};

    reset_n_i = 1'b0;
    job_v_i = '0; job_a_ptr_i = '0; job_b_ptr_i = '0; job_res_ptr_i = '0; job_len_i = '0;
    cmd_yumi_i = 1'b0; resp_v_i = 1'b0; resp_data_i = '0; done_yumi_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check_zero("reset");
    @(negedge clk_i) reset_n_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      clear_logs();
      job_v_i = '0;
      set_desc(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].len);
      done_on = vecs[i].done_on;
      job_v_i[vecs[i].req] = 1'b1;
      run_until_done(1, 200, $sformatf("v%0d", i));

      exp_q.delete();
      if (!vecs[i].exp_fast) begin
        exp_q.push_back('{1'b1, 40'h000, 64'(vecs[i].a)});
        exp_q.push_back('{1'b1, 40'h040, 64'(vecs[i].b)});
        exp_q.push_back('{1'b1, 40'h080, 64'(vecs[i].len)});
        exp_q.push_back('{1'b1, 40'h140, 64'(vecs[i].res)});
        exp_q.push_back('{1'b1, 40'h0C0, 64'h1});
        for (int k = 0; k < vecs[i].exp_reads; k++) exp_q.push_back('{1'b0, 40'h100, 64'h0});
      end
      check($sformatf("v%0d_cmd_count", i), cmd_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < cmd_log.size(); k++)
        check($sformatf("v%0d_cmd%0d", i, k), cmd_log[k], exp_q[k]);
      check($sformatf("v%0d_grant_id", i), (grant_log.size() > 0) ? grant_log[0] : -1, vecs[i].req);
      if (done_id_q.size() > 0) begin
        check($sformatf("v%0d_done_id", i),  done_id_q[0],  vecs[i].req);
        check($sformatf("v%0d_done_err", i), done_err_q[0], vecs[i].exp_err);
      end
      if (vecs[i].exp_fast)
        check($sformatf("v%0d_err_latency_le3", i), (done_cyc - grant_cyc) <= 3, 1);
    end

    // Command acceptance withheld on WR_B: command must hold steady and not advance.
    begin
      bit found = 0;
      clear_logs();
      job_v_i = '0;
      set_desc(1, 40'h111, 40'h222, 40'h333, 4'd2);
      done_on = 1;
      hold_on = 1;
      job_v_i[1] = 1'b1;
      for (int c = 0; c < 100 && !found; c++) begin
        step();
        if (cmd_v_o && cmd_addr_o == 40'h040) found = 1;
      end
      check("stall_reached", found, 1);
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("stall%0d_cmd_v", k),    cmd_v_o,    1);
        check($sformatf("stall%0d_cmd_addr", k), cmd_addr_o, 40'h040);
        check($sformatf("stall%0d_cmd_data", k), cmd_data_o, 64'h222);
        check($sformatf("stall%0d_progress", k), cmd_log.size(), 1);
      end
      hold_on = 0;
      run_until_done(1, 200, "stall");
      check("stall_cmd_count", cmd_log.size(), 6);
      if (cmd_log.size() > 1) check("stall_cmd_b", cmd_log[1], {1'b1, 40'h040, 64'h222});
      if (done_id_q.size() > 0) check("stall_done_err", done_err_q[0], 0);
    end

    // Reset while polling abandons the job silently and restores the arbiter pointer.
    begin
      bit found = 0;
      clear_logs();
      job_v_i = '0;
      set_desc(0, 40'h7000, 40'h8000, 40'h9000, 4'd3);
      done_on = 0;
      job_v_i[0] = 1'b1;
      for (int c = 0; c < 100 && !found; c++) begin
        step();
        if (cmd_v_o && cmd_addr_o == 40'h100) found = 1;
      end
      check("poll_reached", found, 1);
      @(negedge clk_i);
      reset_n_i = 1'b0;
      job_v_i = '0; cmd_yumi_i = 1'b0; resp_v_i = 1'b0; done_yumi_i = 1'b0;
      resp_pend = 0; drop_mask = '0;
      @(posedge clk_i);
      #1 check_zero("midreset");
      @(negedge clk_i) reset_n_i = 1'b1;
      clear_logs();
      repeat (3) step();
      check("midreset_no_done", done_id_q.size(), 0);
    end

    // Both requesters always valid: grants alternate, each job completes before the next grant.
    clear_logs();
    set_desc(0, 40'hA0, 40'hB0, 40'hC0, 4'd1);
    set_desc(1, 40'hA1, 40'hB1, 40'hC1, 4'd1);
    done_on    = 1;
    keep_valid = 1;
    job_v_i    = 2'b11;
    run_until_done(4, 400, "alt");
    job_v_i    = '0;
    keep_valid = 0;
    check("alt_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("alt_grant%0d", k), grant_log[k], alt_exp[k]);
    for (int k = 0; k < 4 && k < done_id_q.size(); k++) begin
      check($sformatf("alt_done_id%0d", k),  done_id_q[k],  alt_exp[k]);
      check($sformatf("alt_done_err%0d", k), done_err_q[k], 0);
    end
    check("alt_no_overlap", bad_grants, 0);
    repeat (3) step();
    check("alt_idle_after", done_id_q.size(), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
